// File: rtl/xif_mem_responder.sv
// Single-outstanding memory responder for a coprocessor memory interface.
// Accepts one request at a time, checks alignment, performs a single write or
// read on the data bus with a bounded wait, then returns a one-cycle result.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | ready for a request; misaligned requests are rejected here
// S_WRITE  | store on the write bus, waiting for dmem_wvalid or timeout
// S_READ   | load on the read bus, waiting for dmem_rvalid or timeout
// S_RESULT | one-cycle mem_result pulse with latched id/rdata/err
module xif_mem_responder #(
    parameter int X_ID_WIDTH     = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [X_ID_WIDTH-1:0] mem_req_id,
    input  logic [31:0]           mem_req_addr,
    input  logic                  mem_req_we,
    input  logic [2:0]            mem_req_size,
    input  logic [3:0]            mem_req_be,
    input  logic [31:0]           mem_req_wdata,
    output logic                  mem_resp_exc,
    output logic [5:0]            mem_resp_exccode,
    output logic                  mem_result_valid,
    output logic [X_ID_WIDTH-1:0] mem_result_id,
    output logic [31:0]           mem_result_rdata,
    output logic                  mem_result_err,
    output logic                  dmem_wready,
    input  logic                  dmem_wvalid,
    output logic [31:0]           dmem_waddr,
    output logic [31:0]           dmem_wdata,
    output logic [3:0]            dmem_wstrb,
    output logic                  dmem_rready,
    input  logic                  dmem_rvalid,
    output logic [31:0]           dmem_raddr,
    input  logic                  dmem_rresp,
    input  logic [31:0]           dmem_rdata
);

    // A zero limit disables the timeout; keep a 1-bit counter in that case.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_READ   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        wait_cnt;
    logic [X_ID_WIDTH-1:0]   id_q;
    logic [31:0]             addr_q;
    logic                    we_q;
    logic [3:0]              be_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic                    err_q;

    logic accept;
    logic misaligned;
    logic legal_accept;
    logic timeout_hit;

    assign misaligned = (mem_req_size > 3'd2)
                     || ((mem_req_size == 3'd1) && mem_req_addr[0])
                     || ((mem_req_size == 3'd2) && (mem_req_addr[1:0] != 2'b00));
    assign accept       = mem_valid && mem_ready;
    assign legal_accept = accept && !misaligned;
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LIMIT);

    // State register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode and all outputs; bus outputs are zero outside their state.
    always_comb begin
        state_nxt        = state;
        mem_ready        = 1'b0;
        mem_resp_exc     = 1'b0;
        mem_resp_exccode = 6'd0;
        mem_result_valid = 1'b0;
        mem_result_id    = '0;
        mem_result_rdata = 32'd0;
        mem_result_err   = 1'b0;
        dmem_wready      = 1'b0;
        dmem_waddr       = 32'd0;
        dmem_wdata       = 32'd0;
        dmem_wstrb       = 4'd0;
        dmem_rready      = 1'b0;
        dmem_raddr       = 32'd0;
        case (state)
            S_IDLE: begin
                mem_ready = resetb;
                if (accept && misaligned) begin
                    mem_resp_exc     = 1'b1;
                    mem_resp_exccode = mem_req_we ? 6'd6 : 6'd4;
                end
                if (legal_accept) begin
                    if (!mem_req_we)              state_nxt = S_READ;
                    else if (mem_req_be == 4'd0)  state_nxt = S_RESULT;
                    else                          state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                dmem_wready = we_q;
                dmem_waddr  = addr_q;
                dmem_wdata  = wdata_q;
                dmem_wstrb  = be_q;
                if (dmem_wvalid || timeout_hit) state_nxt = S_RESULT;
            end
            S_READ: begin
                dmem_rready = !we_q;
                dmem_raddr  = addr_q;
                if (dmem_rvalid || timeout_hit) state_nxt = S_RESULT;
            end
            S_RESULT: begin
                mem_result_valid = 1'b1;
                mem_result_id    = id_q;
                mem_result_rdata = rdata_q;
                mem_result_err   = err_q;
                state_nxt        = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latch, response capture and bus wait counter.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wait_cnt <= '0;
            id_q     <= '0;
            addr_q   <= 32'd0;
            we_q     <= 1'b0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (legal_accept) begin
                        id_q     <= mem_req_id;
                        addr_q   <= mem_req_addr;
                        we_q     <= mem_req_we;
                        be_q     <= mem_req_be;
                        wdata_q  <= mem_req_wdata;
                        rdata_q  <= 32'd0;
                        err_q    <= 1'b0;
                        wait_cnt <= '0;
                    end
                end
                S_WRITE, S_READ: begin
                    if ((state == S_WRITE) ? dmem_wvalid : dmem_rvalid) begin
                        // A response in the timeout cycle still completes normally.
                        rdata_q <= (state == S_READ) ? dmem_rdata : 32'd0;
                        err_q   <= (state == S_READ) ? !dmem_rresp : 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= 32'd0;
                        err_q   <= 1'b1;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xif_mem_responder.sv
// Randomized self-checking bench for xif_mem_responder (timeout limit 8).
// The model works per transaction: alignment rule, response delay and
// timeout limit decide the expected exception, result cycle and payload.
module tb_xif_mem_responder;

    localparam int IDW = 3;
    localparam int TO  = 8;

    logic            clk = 1'b0;
    logic            resetb = 1'b0;
    logic            mem_valid = 1'b0;
    logic            mem_ready;
    logic [IDW-1:0]  mem_req_id = '0;
    logic [31:0]     mem_req_addr = '0;
    logic            mem_req_we = 1'b0;
    logic [2:0]      mem_req_size = '0;
    logic [3:0]      mem_req_be = '0;
    logic [31:0]     mem_req_wdata = '0;
    logic            mem_resp_exc;
    logic [5:0]      mem_resp_exccode;
    logic            mem_result_valid;
    logic [IDW-1:0]  mem_result_id;
    logic [31:0]     mem_result_rdata;
    logic            mem_result_err;
    logic            dmem_wready;
    logic            dmem_wvalid = 1'b0;
    logic [31:0]     dmem_waddr;
    logic [31:0]     dmem_wdata;
    logic [3:0]      dmem_wstrb;
    logic            dmem_rready;
    logic            dmem_rvalid = 1'b0;
    logic [31:0]     dmem_raddr;
    logic            dmem_rresp = 1'b0;
    logic [31:0]     dmem_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    xif_mem_responder #(.X_ID_WIDTH(IDW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetb(resetb),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_req_id(mem_req_id), .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
        .mem_req_size(mem_req_size), .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
        .mem_resp_exc(mem_resp_exc), .mem_resp_exccode(mem_resp_exccode),
        .mem_result_valid(mem_result_valid), .mem_result_id(mem_result_id),
        .mem_result_rdata(mem_result_rdata), .mem_result_err(mem_result_err),
        .dmem_wready(dmem_wready), .dmem_wvalid(dmem_wvalid), .dmem_waddr(dmem_waddr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rready(dmem_rready), .dmem_rvalid(dmem_rvalid), .dmem_raddr(dmem_raddr),
        .dmem_rresp(dmem_rresp), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_misaligned(input logic [31:0] addr, input logic [2:0] size);
        if (size > 2) return 1'b1;
        if (size == 1) return (addr % 2) != 0;
        if (size == 2) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    // One request; k = response delay in cycles after the bus request starts
    // (k > TO or k < 0 means no response). hold keeps mem_valid high throughout.
    task automatic run_txn(input logic [IDW-1:0] id, input logic [31:0] addr,
                           input logic we, input logic [2:0] size, input logic [3:0] be,
                           input logic [31:0] wdata, input int k, input logic rresp,
                           input logic [31:0] rdata, input bit hold);
        bit          mis;
        bit          done;
        bit          got_resp;
        logic [31:0] exp_rdata;
        logic        exp_err;
        mis = is_misaligned(addr, size);
        @(negedge clk);
        mem_valid = 1'b1; mem_req_id = id; mem_req_addr = addr; mem_req_we = we;
        mem_req_size = size; mem_req_be = be; mem_req_wdata = wdata;
        #1;
        chk("accept_ready", mem_ready, 1'b1);
        chk("accept_exc", mem_resp_exc, mis);
        chk("accept_exccode", mem_resp_exccode, mis ? (we ? 6'd6 : 6'd4) : 6'd0);
        @(negedge clk);
        if (!hold) mem_valid = 1'b0;
        #1;
        chk("post_exc", mem_resp_exc, 1'b0);
        if (mis) begin
            chk("mis_ready", mem_ready, 1'b1);
            chk("mis_wready", dmem_wready, 1'b0);
            chk("mis_rready", dmem_rready, 1'b0);
            chk("mis_result", mem_result_valid, 1'b0);
            return;
        end
        if (we && be == 4'd0) begin
            chk("be0_wready", dmem_wready, 1'b0);
            chk("be0_result", mem_result_valid, 1'b1);
            chk("be0_id", mem_result_id, id);
            chk("be0_err", mem_result_err, 1'b0);
            chk("be0_rdata", mem_result_rdata, 32'd0);
            return;
        end
        done = 0;
        got_resp = (k >= 0 && k <= TO);
        for (int c = 0; c <= TO && !done; c++) begin
            dmem_rdata = $urandom;
            dmem_rresp = $urandom_range(0, 1);
            if (c == k) begin
                if (we) dmem_wvalid = 1'b1;
                else begin dmem_rvalid = 1'b1; dmem_rdata = rdata; dmem_rresp = rresp; end
            end
            #1;
            chk("busy_ready", mem_ready, 1'b0);
            chk("busy_result", mem_result_valid, 1'b0);
            chk("bus_wready", dmem_wready, we);
            chk("bus_rready", dmem_rready, !we);
            if (we) begin
                chk("bus_waddr", dmem_waddr, addr);
                chk("bus_wdata", dmem_wdata, wdata);
                chk("bus_wstrb", dmem_wstrb, be);
            end else begin
                chk("bus_raddr", dmem_raddr, addr);
            end
            if (c == k || c == TO) done = 1;
            @(negedge clk);
            dmem_wvalid = 1'b0; dmem_rvalid = 1'b0;
        end
        exp_err   = got_resp ? (we ? 1'b0 : !rresp) : 1'b1;
        exp_rdata = (got_resp && !we) ? rdata : 32'd0;
        #1;
        chk("res_valid", mem_result_valid, 1'b1);
        chk("res_id", mem_result_id, id);
        chk("res_rdata", mem_result_rdata, exp_rdata);
        chk("res_err", mem_result_err, exp_err);
        chk("res_wready", dmem_wready, 1'b0);
        chk("res_rready", dmem_rready, 1'b0);
        chk("res_ready", mem_ready, 1'b0);
        chk("res_exc", mem_resp_exc, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", mem_ready, 1'b0);
        chk("rst_result", mem_result_valid, 1'b0);
        chk("rst_wready", dmem_wready, 1'b0);
        chk("rst_rready", dmem_rready, 1'b0);
        chk("rst_waddr", dmem_waddr, 32'd0);
        chk("rst_raddr", dmem_raddr, 32'd0);
        @(negedge clk);
        resetb = 1'b1;
        #1;
        chk("rel_ready", mem_ready, 1'b1);

        // Directed scenarios
        run_txn(3'd5, 32'h0000_1004, 1'b0, 3'd2, 4'hF, 32'd0, 3, 1'b1, 32'hDEAD_BEEF, 0);
        run_txn(3'd2, 32'h0000_2000, 1'b1, 3'd2, 4'hF, 32'hCAFE_F00D, 0, 1'b1, 32'd0, 0);
        run_txn(3'd1, 32'h0000_3001, 1'b0, 3'd1, 4'h3, 32'd0, 0, 1'b1, 32'd0, 0);
        run_txn(3'd1, 32'h0000_3002, 1'b1, 3'd2, 4'hF, 32'h1234_5678, 0, 1'b1, 32'd0, 0);
        run_txn(3'd4, 32'h0000_4000, 1'b0, 3'd2, 4'hF, 32'd0, 1, 1'b0, 32'h5555_AAAA, 0);
        run_txn(3'd6, 32'h0000_5000, 1'b0, 3'd2, 4'hF, 32'd0, -1, 1'b1, 32'd0, 0);
        run_txn(3'd7, 32'h0000_6000, 1'b1, 3'd0, 4'h1, 32'hFF, -1, 1'b1, 32'd0, 0);
        run_txn(3'd3, 32'h0000_7000, 1'b0, 3'd2, 4'hF, 32'd0, TO, 1'b1, 32'h0BAD_F00D, 0);
        run_txn(3'd0, 32'h0000_8000, 1'b1, 3'd2, 4'h0, 32'h1111_2222, 0, 1'b1, 32'd0, 0);
        // Back-to-back with mem_valid held high
        run_txn(3'd1, 32'h0000_9000, 1'b0, 3'd2, 4'hF, 32'd0, 2, 1'b1, 32'hA5A5_0001, 1);
        run_txn(3'd2, 32'h0000_9004, 1'b1, 3'd1, 4'h3, 32'hBEEF, 1, 1'b1, 32'd0, 0);

        // Bus responses outside WRITE/READ are ignored
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_wvalid = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_wvalid = 1'b0;
        #1;
        chk("idle_ack_result", mem_result_valid, 1'b0);
        chk("idle_ack_ready", mem_ready, 1'b1);

        // Reset pulse during READ
        @(negedge clk);
        mem_valid = 1'b1; mem_req_id = 3'd6; mem_req_addr = 32'h0000_A000;
        mem_req_we = 1'b0; mem_req_size = 3'd2; mem_req_be = 4'hF;
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        chk("rstmid_rready_before", dmem_rready, 1'b1);
        @(negedge clk);
        #1;
        resetb = 1'b0;
        #1;
        chk("rstmid_rready", dmem_rready, 1'b0);
        chk("rstmid_raddr", dmem_raddr, 32'd0);
        chk("rstmid_ready", mem_ready, 1'b0);
        @(negedge clk);
        resetb = 1'b1;
        #1;
        chk("rstmid_rel_ready", mem_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("rstmid_no_result", mem_result_valid, 1'b0);
            chk("rstmid_no_rready", dmem_rready, 1'b0);
        end
        run_txn(3'd3, 32'h0000_B008, 1'b0, 3'd2, 4'hF, 32'd0, 2, 1'b1, 32'h7777_8888, 0);

        // Randomized transactions
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            run_txn(IDW'($urandom), a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                    4'($urandom), $urandom, $urandom_range(0, 10), 1'($urandom_range(0, 1)),
                    $urandom, 0);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xif_mem_responder.md
XIF_MEM_RESPONDER -- requirements
Module: xif_mem_responder

Interface
REQ-001 SHALL have parameter X_ID_WIDTH, default 3, the coprocessor transaction ID width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, the bus wait limit in cycles; 0 disables the timeout.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state is updated on the rising edge.
REQ-004 SHALL have port resetb, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port mem_valid, input, 1 bit: the coprocessor presents a memory request.
REQ-006 SHALL have port mem_ready, output, 1 bit: this block accepts the request.
REQ-007 SHALL have request input ports: mem_req_id (X_ID_WIDTH), mem_req_addr (32), mem_req_we (1), mem_req_size (3; 0=byte, 1=half, 2=word), mem_req_be (4), mem_req_wdata (32).
REQ-008 SHALL have output ports mem_resp_exc (1) and mem_resp_exccode (6): the exception response, valid during the accept cycle only.
REQ-009 SHALL have output ports mem_result_valid (1), mem_result_id (X_ID_WIDTH), mem_result_rdata (32) and mem_result_err (1).
REQ-010 SHALL have write-bus ports: dmem_wready out (request), dmem_wvalid in (ack), dmem_waddr out 32, dmem_wdata out 32, dmem_wstrb out 4.
REQ-011 SHALL have read-bus ports: dmem_rready out (request), dmem_rvalid in (data valid), dmem_raddr out 32, dmem_rresp in 1 (1=OK), dmem_rdata in 32.

Function
REQ-012 SHALL implement a single-outstanding FSM with states IDLE, WRITE, READ and RESULT.
REQ-013 SHALL drive mem_ready=1 only in IDLE; a request is accepted in the cycle where mem_valid and mem_ready are both 1.
REQ-014 SHALL treat a request as misaligned when size=1 and addr[0]!=0, when size=2 and addr[1:0]!=0, or when size>2.
REQ-015 SHALL handle a misaligned accepted request as follows: mem_resp_exc=1 combinationally in the accept cycle, exccode=6 if we=1 else 4, no bus access, no mem_result, and the FSM stays in IDLE.
REQ-016 SHALL drive mem_resp_exc=0 and mem_resp_exccode=0 in every other cycle.
REQ-017 SHALL, on a legal accept, latch id, addr, we, be and wdata, then go to WRITE if we=1, otherwise to READ.
REQ-018 SHALL skip the bus for a legal store with be=4'b0000 and go directly to RESULT with err=0.
REQ-019 SHALL, in WRITE, hold dmem_wready=1 with waddr, wdata and wstrb equal to the latched addr, wdata and be, stable until dmem_wvalid=1.
REQ-020 SHALL, on dmem_wvalid=1 in WRITE, go to RESULT with err=0 and rdata=0.
REQ-021 SHALL, in READ, hold dmem_rready=1 with raddr equal to the latched addr until dmem_rvalid=1.
REQ-022 SHALL, on dmem_rvalid=1 in READ, capture rdata=dmem_rdata and err=~dmem_rresp, then go to RESULT.
REQ-023 SHALL drive dmem_wready and dmem_rready to 0 outside WRITE and READ respectively, and never assert both at once.
REQ-024 SHALL drive mem_result_valid=1 in RESULT for exactly one cycle, with the latched id, rdata and err, then return to IDLE; mem_result has no backpressure.
REQ-025 SHALL use a wait counter that clears on entry to WRITE or READ and increments each cycle the ack or valid is absent.
REQ-026 SHALL, when TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, drop the bus request and go to RESULT with err=1 and rdata=0.
REQ-027 SHALL give ack or valid in the same cycle as the timeout precedence, completing normally.
REQ-028 SHALL size the counter to hold TIMEOUT_CYCLES and never wrap.
REQ-029 SHALL have the following latency: accept at cycle T, bus request from T+1; a response at T+1+k gives mem_result_valid at T+2+k; minimum request-to-result is 2 cycles.
REQ-030 SHALL ignore dmem_wvalid and dmem_rvalid outside WRITE and READ.

Reset
REQ-031 SHALL, while resetb=0, force state IDLE, counter 0, all latched fields 0, mem_ready=0, mem_result_valid=0, dmem_wready=0, dmem_rready=0, and all address, data and strobe outputs to 0.
REQ-032 SHALL, when reset is asserted mid-transaction, abort it with no mem_result issued; after release, mem_ready=1 on the first clock edge.

Verification
REQ-033 SHALL be verified with the following scenario: word load at addr 0x0000_1004, id 5, rvalid after 3 cycles with rdata 0xDEAD_BEEF and rresp=1 -> one-cycle result, id 5, rdata 0xDEAD_BEEF, err 0, 5 cycles after accept.
REQ-034 SHALL be verified with the following scenario: store word 0xCAFE_F00D to 0x0000_2000, be 4'hF, wvalid immediately -> waddr, wdata and wstrb correct, result err 0, 2 cycles after accept.
REQ-035 SHALL be verified with the following scenario: half load at addr 0x...1 and word store at addr 0x...2 -> exc=1 with exccode 4 and 6 respectively, no dmem request, no result.
REQ-036 SHALL be verified with the following scenario: read with rresp=0 -> err 1; read with no rvalid and TIMEOUT_CYCLES=8 -> rready dropped and err 1, rdata 0, at counter=8.
REQ-037 SHALL be verified with the following scenario: back-to-back mem_valid held high -> second accept only after RESULT, mem_ready low in the meantime; store with be=0 -> result without bus activity.
REQ-038 SHALL be verified with the following scenario: resetb pulsed low during READ -> rready drops immediately, no result, and the next request completes normally.
